msg_tgen_chk: RTL

- Parametrised single-clock debug message generator/checker: successor to the fixed one-channel packet I/O test block.
- Source side emits whole messages (src, dst, dat, red) over a 4-phase req/ack channel.
- Sink side accepts messages over a 4-phase channel and checks src, redundancy, destination range and data sequence, with wrap-around.
- Adds message-count limit, sticky error flags, a saturating error counter and sent/received counters. Sits at the edge of a test fabric, driving LEDs/displays.

---
 rtl/msg_tgen_chk.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/msg_tgen_chk.sv
// Debug message generator/checker: emits a stepped message stream on a 4-phase
// source channel and validates messages arriving on a 4-phase sink channel.
`ifndef NS_ADDRESS_SIZE
  `define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
  `define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
  `define NS_REDUN_SIZE 4
`endif

module calc_redun #(
  parameter int ASZ = 8,
  parameter int DSZ = 8,
  parameter int RSZ = 4
) (
  input  logic [ASZ-1:0] src,
  input  logic [ASZ-1:0] dst,
  input  logic [DSZ-1:0] dat,
  output logic [RSZ-1:0] red
);
  localparam int W = 2 * ASZ + DSZ;
  localparam int N = (W + RSZ - 1) / RSZ;

  logic [N*RSZ-1:0] padded;

  // XOR-fold the concatenated fields into RSZ-wide chunks, zero-padding the top.
  always_comb begin
    padded = (N*RSZ)'({src, dst, dat});
    red    = '0;
    for (int i = 0; i < N; i++) red = red ^ padded[i*RSZ +: RSZ];
  end
endmodule

module msg_tgen_chk #(
  parameter int MIN_ADDR = 1,
  parameter int MAX_ADDR = 1,
  parameter int SRC_ADDR = 3,
  parameter int INIT_DAT = 5,
  parameter int SEQ_STEP = 1,
  parameter int MAX_MSGS = 0,
  parameter int ASZ      = `NS_ADDRESS_SIZE,
  parameter int DSZ      = `NS_DATA_SIZE,
  parameter int RSZ      = `NS_REDUN_SIZE,
  parameter int CW       = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  output logic           o_req,
  input  logic           o_ack,
  output logic [ASZ-1:0] o_src,
  output logic [ASZ-1:0] o_dst,
  output logic [DSZ-1:0] o_dat,
  output logic [RSZ-1:0] o_red,
  input  logic           i_req,
  output logic           i_ack,
  input  logic [ASZ-1:0] i_src,
  input  logic [ASZ-1:0] i_dst,
  input  logic [DSZ-1:0] i_dat,
  input  logic [RSZ-1:0] i_red,
  output logic           gen_done,
  output logic           err_src,
  output logic           err_red,
  output logic           err_dst,
  output logic           err_seq,
  output logic [CW-1:0]  err_cnt,
  output logic [CW-1:0]  sent_cnt,
  output logic [CW-1:0]  rcvd_cnt,
  output logic [DSZ-1:0] last_dat
);
  localparam logic [ASZ-1:0] SRC_A = ASZ'(SRC_ADDR);
  localparam logic [ASZ-1:0] MIN_A = ASZ'(MIN_ADDR);
  localparam logic [ASZ-1:0] MAX_A = ASZ'(MAX_ADDR);
  localparam logic [DSZ-1:0] DAT0  = DSZ'(INIT_DAT);
  localparam logic [DSZ-1:0] STEP  = DSZ'(SEQ_STEP);
  localparam logic [CW-1:0]  MAXM  = CW'(MAX_MSGS);

  typedef enum logic [2:0] {G_IDLE, G_BUILD, G_REQ, G_REL, G_DONE} gen_state_t;
  typedef enum logic [1:0] {C_IDLE, C_CHK, C_ACK} chk_state_t;

  gen_state_t     g_state_q, g_state_d;
  logic           o_req_q, o_req_d;
  logic [ASZ-1:0] o_src_q, o_src_d, o_dst_q, o_dst_d;
  logic [DSZ-1:0] o_dat_q, o_dat_d;
  logic [RSZ-1:0] o_red_q, o_red_d;
  logic [CW-1:0]  sent_cnt_q, sent_cnt_d;
  logic           gen_done_q, gen_done_d;

  logic [ASZ-1:0] g_src, g_dst;
  logic [DSZ-1:0] g_dat;
  logic [RSZ-1:0] g_red;

  // During reset the encoder sees the reset field values so o_red resets consistently.
  assign g_src = reset ? SRC_A : o_src_q;
  assign g_dst = reset ? MIN_A : o_dst_q;
  assign g_dat = reset ? DAT0  : o_dat_q;

  calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_gen_redun (
    .src(g_src), .dst(g_dst), .dat(g_dat), .red(g_red)
  );

  always_comb begin
    g_state_d  = g_state_q;
    o_req_d    = o_req_q;
    o_src_d    = o_src_q;
    o_dst_d    = o_dst_q;
    o_dat_d    = o_dat_q;
    o_red_d    = o_red_q;
    sent_cnt_d = sent_cnt_q;
    gen_done_d = gen_done_q;
    case (g_state_q)
      G_IDLE:  if (en && !gen_done_q) g_state_d = G_BUILD;
      G_BUILD: begin
        o_red_d   = g_red;
        o_req_d   = 1'b1;
        g_state_d = G_REQ;
      end
      G_REQ: if (o_ack) begin
        o_req_d    = 1'b0;
        sent_cnt_d = sent_cnt_q + 1'b1;
        g_state_d  = G_REL;
      end
      G_REL: if (!o_ack) begin
        o_dst_d = (o_dst_q == MAX_A) ? MIN_A : o_dst_q + 1'b1;
        o_dat_d = o_dat_q + STEP;
        if ((MAX_MSGS != 0) && (sent_cnt_q == MAXM)) begin
          gen_done_d = 1'b1;
          g_state_d  = G_DONE;
        end else begin
          g_state_d = G_IDLE;
        end
      end
      G_DONE:  g_state_d = G_DONE;
      default: g_state_d = G_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      g_state_q  <= G_IDLE;
      o_req_q    <= 1'b0;
      o_src_q    <= SRC_A;
      o_dst_q    <= MIN_A;
      o_dat_q    <= DAT0;
      o_red_q    <= g_red;
      sent_cnt_q <= '0;
      gen_done_q <= 1'b0;
    end else begin
      g_state_q  <= g_state_d;
      o_req_q    <= o_req_d;
      o_src_q    <= o_src_d;
      o_dst_q    <= o_dst_d;
      o_dat_q    <= o_dat_d;
      o_red_q    <= o_red_d;
      sent_cnt_q <= sent_cnt_d;
      gen_done_q <= gen_done_d;
    end
  end

  chk_state_t     c_state_q, c_state_d;
  logic           i_ack_q, i_ack_d;
  logic [ASZ-1:0] cap_src_q, cap_src_d, cap_dst_q, cap_dst_d;
  logic [DSZ-1:0] cap_dat_q, cap_dat_d;
  logic [RSZ-1:0] cap_red_q, cap_red_d, c_red;
  logic [DSZ-1:0] ref_q, ref_d, last_dat_q, last_dat_d;
  logic           ref_vld_q, ref_vld_d;
  logic           err_src_q, err_src_d, err_red_q, err_red_d;
  logic           err_dst_q, err_dst_d, err_seq_q, err_seq_d;
  logic [CW-1:0]  err_cnt_q, err_cnt_d, rcvd_cnt_q, rcvd_cnt_d;
  logic           e_src, e_red, e_dst, e_seq;

  calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_chk_redun (
    .src(cap_src_q), .dst(cap_dst_q), .dat(cap_dat_q), .red(c_red)
  );

  always_comb begin
    e_src = (cap_src_q != SRC_A);
    e_red = (cap_red_q != c_red);
    e_dst = (cap_dst_q < MIN_A) || (cap_dst_q > MAX_A);
    e_seq = ref_vld_q && (cap_dat_q != ref_q + STEP);
  end

  always_comb begin
    c_state_d  = c_state_q;
    i_ack_d    = i_ack_q;
    cap_src_d  = cap_src_q;
    cap_dst_d  = cap_dst_q;
    cap_dat_d  = cap_dat_q;
    cap_red_d  = cap_red_q;
    ref_d      = ref_q;
    ref_vld_d  = ref_vld_q;
    last_dat_d = last_dat_q;
    err_src_d  = err_src_q;
    err_red_d  = err_red_q;
    err_dst_d  = err_dst_q;
    err_seq_d  = err_seq_q;
    err_cnt_d  = err_cnt_q;
    rcvd_cnt_d = rcvd_cnt_q;
    case (c_state_q)
      C_IDLE: if (i_req && !i_ack_q) begin
        cap_src_d = i_src;
        cap_dst_d = i_dst;
        cap_dat_d = i_dat;
        cap_red_d = i_red;
        c_state_d = C_CHK;
      end
      C_CHK: begin
        err_src_d = err_src_q | e_src;
        err_red_d = err_red_q | e_red;
        err_dst_d = err_dst_q | e_dst;
        err_seq_d = err_seq_q | e_seq;
        if ((e_src || e_red || e_dst || e_seq) && (err_cnt_q != '1))
          err_cnt_d = err_cnt_q + 1'b1;
        ref_d      = cap_dat_q;
        ref_vld_d  = 1'b1;
        last_dat_d = cap_dat_q;
        rcvd_cnt_d = rcvd_cnt_q + 1'b1;
        i_ack_d    = 1'b1;
        c_state_d  = C_ACK;
      end
      C_ACK: if (!i_req) begin
        i_ack_d   = 1'b0;
        c_state_d = C_IDLE;
      end
      default: c_state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_state_q  <= C_IDLE;
      i_ack_q    <= 1'b0;
      cap_src_q  <= '0;
      cap_dst_q  <= '0;
      cap_dat_q  <= '0;
      cap_red_q  <= '0;
      ref_q      <= '0;
      ref_vld_q  <= 1'b0;
      last_dat_q <= '0;
      err_src_q  <= 1'b0;
      err_red_q  <= 1'b0;
      err_dst_q  <= 1'b0;
      err_seq_q  <= 1'b0;
      err_cnt_q  <= '0;
      rcvd_cnt_q <= '0;
    end else begin
      c_state_q  <= c_state_d;
      i_ack_q    <= i_ack_d;
      cap_src_q  <= cap_src_d;
      cap_dst_q  <= cap_dst_d;
      cap_dat_q  <= cap_dat_d;
      cap_red_q  <= cap_red_d;
      ref_q      <= ref_d;
      ref_vld_q  <= ref_vld_d;
      last_dat_q <= last_dat_d;
      err_src_q  <= err_src_d;
      err_red_q  <= err_red_d;
      err_dst_q  <= err_dst_d;
      err_seq_q  <= err_seq_d;
      err_cnt_q  <= err_cnt_d;
      rcvd_cnt_q <= rcvd_cnt_d;
    end
  end

  assign o_req    = o_req_q;
  assign o_src    = o_src_q;
  assign o_dst    = o_dst_q;
  assign o_dat    = o_dat_q;
  assign o_red    = o_red_q;
  assign sent_cnt = sent_cnt_q;
  assign gen_done = gen_done_q;
  assign i_ack    = i_ack_q;
  assign err_src  = err_src_q;
  assign err_red  = err_red_q;
  assign err_dst  = err_dst_q;
  assign err_seq  = err_seq_q;
  assign err_cnt  = err_cnt_q;
  assign rcvd_cnt = rcvd_cnt_q;
  assign last_dat = last_dat_q;
endmodule
